// File: rtl/instr_memory.sv
// instr_memory: loadable instruction word array behind the processor fetch
// port. Reads go through a 1..4 stage pipeline that freezes on Stall. Each
// fetch carries a valid bit and an address-error bit to the output stage.
// Program words are written through a separate load port.
module instr_memory #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH       = 64,
  parameter int                    LATENCY     = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_INSTR = '0
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  ReqEn,
  input  logic [ADDR_WIDTH-1:0] InstrAddr,
  input  logic                  Stall,
  output logic [DATA_WIDTH-1:0] InstrMem,
  output logic                  InstrValid,
  output logic                  AddrError,
  input  logic                  LoadEn,
  input  logic [ADDR_WIDTH-1:0] LoadAddr,
  input  logic [DATA_WIDTH-1:0] LoadData
);

  localparam int IDX_W = $clog2(DEPTH);

  // Reject unsupported configurations at elaboration time.
  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("instr_memory: LATENCY must be in 1..4");
    end
    if (DEPTH < 2 || (1 << IDX_W) != DEPTH) begin : g_bad_depth
      $error("instr_memory: DEPTH must be a power of two >= 2");
    end
  endgenerate

  // Word-aligned and inside the array: low two bits clear, nothing above
  // the word index set.
  logic             w_fetch_legal;
  logic             w_load_legal;
  logic [IDX_W-1:0] w_fetch_idx;
  logic [IDX_W-1:0] w_load_idx;
  logic             w_accept;

  assign w_fetch_legal = (InstrAddr[1:0] == 2'b00) && ((InstrAddr >> (IDX_W + 2)) == '0);
  assign w_load_legal  = (LoadAddr[1:0]  == 2'b00) && ((LoadAddr  >> (IDX_W + 2)) == '0);
  assign w_fetch_idx   = InstrAddr[IDX_W+1:2];
  assign w_load_idx    = LoadAddr[IDX_W+1:2];
  assign w_accept      = ReqEn && !Stall;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Program-load write port; illegal addresses are dropped.
  // NOTE: the array has no reset branch on purpose -- its contents survive
  // nReset, and leaving it out keeps it mappable onto plain RAM.
  always_ff @(posedge Clock) begin
    if (LoadEn && w_load_legal) begin
      r_mem[w_load_idx] <= LoadData;
    end
  end

  // Stage-1 payload: array word for a legal fetch, RESET_INSTR otherwise.
  logic [DATA_WIDTH-1:0] w_s1_data;

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_s1_data = RESET_INSTR;
    if (w_accept && w_fetch_legal) begin
      w_s1_data = r_mem[w_fetch_idx];
    end
  end

  logic [DATA_WIDTH-1:0] r_data [LATENCY];
  logic [LATENCY-1:0]    r_valid;
  logic [LATENCY-1:0]    r_err;

  // Read pipeline: shift one stage per non-stalled edge, hold on Stall.
  // The array is read with the pre-edge contents, so a same-edge load to
  // the fetched word returns the old word.
  // NOTE: non-blocking assignments let every stage sample its predecessor's
  // pre-edge value, which is what makes this a shift register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_data[i] <= RESET_INSTR;
      end
      r_valid <= '0;
      r_err   <= '0;
    end else if (!Stall) begin
      r_data[0]  <= w_s1_data;
      r_valid[0] <= w_accept;
      r_err[0]   <= w_accept && !w_fetch_legal;
      for (int i = 1; i < LATENCY; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
        r_err[i]   <= r_err[i-1];
      end
    end
  end

  assign InstrMem   = r_data[LATENCY-1];
  assign InstrValid = r_valid[LATENCY-1];
  assign AddrError  = r_err[LATENCY-1];

endmodule

// File: tb/tb_instr_memory.sv
// Directed bench for instr_memory. Four instances with LATENCY 1..4 share
// one stimulus bus, and each scenario checks the instance it targets.
// Observed values are packed as {valid, error, data}.
module tb_instr_memory;

  logic        clk;
  logic        nReset;
  logic        ReqEn;
  logic [31:0] InstrAddr;
  logic        Stall;
  logic        LoadEn;
  logic [31:0] LoadAddr;
  logic [31:0] LoadData;

  logic [31:0] instr [4];
  logic        valid [4];
  logic        aerr  [4];

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_v;
  logic [33:0] got_v;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    instr_memory #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .DEPTH      (64),
      .LATENCY    (g + 1),
      .RESET_INSTR(32'h00000000)
    ) u_dut (
      .Clock     (clk),
      .nReset    (nReset),
      .ReqEn     (ReqEn),
      .InstrAddr (InstrAddr),
      .Stall     (Stall),
      .InstrMem  (instr[g]),
      .InstrValid(valid[g]),
      .AddrError (aerr[g]),
      .LoadEn    (LoadEn),
      .LoadAddr  (LoadAddr),
      .LoadData  (LoadData)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] obs(input int k);
    return {valid[k], aerr[k], instr[k]};
  endfunction

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ReqEn  = 1'b0;
    LoadEn = 1'b0;
    Stall  = 1'b0;
  endtask

  task automatic flush();
    idle();
    repeat (5) step();
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    LoadEn   = 1'b1;
    LoadAddr = a;
    LoadData = d;
    step();
    LoadEn   = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      got_v = obs(k);
      checks++;
      if (got_v !== 34'h0) begin
        errors++;
        $display("FAIL reset_l%0d got=%h exp=%h", k + 1, got_v, 34'h0);
      end
    end
    step();
    nReset = 1'b1;
    step();
  endtask

  task automatic test_load_single();
    do_load(32'h0000, 32'h3C011234);
    do_load(32'h0004, 32'h34215678);
    do_load(32'h0008, 32'h24020000);
    do_load(32'h0010, 32'h34420005);
    do_load(32'h0014, 32'h70411802);
    ReqEn = 1'b1; InstrAddr = 32'h0000;
    step();
    exp_v = {2'b10, 32'h3C011234}; got_v = obs(0);
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL single_first got=%h exp=%h", got_v, exp_v); end
    InstrAddr = 32'h0004;
    step();
    exp_v = {2'b10, 32'h34215678}; got_v = obs(0);
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL single_second got=%h exp=%h", got_v, exp_v); end
    ReqEn = 1'b0;
    step();
    exp_v = 34'h0; got_v = obs(0);
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL single_bubble got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_deep_pipeline();
    logic [33:0] want [6];
    logic [31:0] addrs [3];
    want[0] = 34'h0; want[1] = 34'h0;
    want[2] = {2'b10, 32'h3C011234};
    want[3] = {2'b10, 32'h34215678};
    want[4] = {2'b10, 32'h24020000};
    want[5] = 34'h0;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    flush();
    for (int e = 0; e < 6; e++) begin
      if (e < 3) begin ReqEn = 1'b1; InstrAddr = addrs[e]; end
      else ReqEn = 1'b0;
      step();
      got_v = obs(2);
      checks++;
      if (got_v !== want[e]) begin
        errors++;
        $display("FAIL deep_l3_edge%0d got=%h exp=%h", e + 1, got_v, want[e]);
      end
    end
  endtask

  task automatic test_illegal();
    flush();
    ReqEn = 1'b1; InstrAddr = 32'h0002;
    step();
    exp_v = {2'b11, 32'h0}; got_v = obs(0);
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL illegal_misaligned got=%h exp=%h", got_v, exp_v); end
    InstrAddr = 32'h0100;
    step();
    got_v = obs(0);
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL illegal_range got=%h exp=%h", got_v, exp_v); end
    ReqEn = 1'b0;
    step();
    got_v = obs(1);
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL illegal_range_l2 got=%h exp=%h", got_v, exp_v); end
    // 0x0100 aliases word 0 if the range check were missing.
    do_load(32'h0100, 32'hDEADBEEF);
    do_load(32'h0001, 32'hDEADBEEF);
    ReqEn = 1'b1; InstrAddr = 32'h0000;
    step();
    exp_v = {2'b10, 32'h3C011234}; got_v = obs(0);
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL illegal_load_dropped got=%h exp=%h", got_v, exp_v); end
    ReqEn = 1'b0;
  endtask

  task automatic test_stall();
    flush();
    ReqEn = 1'b1; InstrAddr = 32'h0010;
    step();
    got_v = obs(1);
    checks++;
    if (got_v !== 34'h0) begin errors++; $display("FAIL stall_l2_accept got=%h exp=%h", got_v, 34'h0); end
    // The request presented during the stall must be ignored.
    Stall = 1'b1; InstrAddr = 32'h0000;
    for (int c = 0; c < 3; c++) begin
      step();
      got_v = obs(1);
      checks++;
      if (got_v !== 34'h0) begin errors++; $display("FAIL stall_l2_hold%0d got=%h exp=%h", c, got_v, 34'h0); end
      exp_v = {2'b10, 32'h34420005}; got_v = obs(0);
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL stall_l1_hold%0d got=%h exp=%h", c, got_v, exp_v); end
    end
    Stall = 1'b0; ReqEn = 1'b0;
    step();
    exp_v = {2'b10, 32'h34420005}; got_v = obs(1);
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL stall_l2_deliver got=%h exp=%h", got_v, exp_v); end
    got_v = obs(0);
    checks++;
    if (got_v !== 34'h0) begin errors++; $display("FAIL stall_req_ignored got=%h exp=%h", got_v, 34'h0); end
    step();
    got_v = obs(1);
    checks++;
    if (got_v !== 34'h0) begin errors++; $display("FAIL stall_l2_after got=%h exp=%h", got_v, 34'h0); end
  endtask

  task automatic test_collision();
    flush();
    LoadEn = 1'b1; LoadAddr = 32'h0014; LoadData = 32'h00000000;
    ReqEn  = 1'b1; InstrAddr = 32'h0014;
    step();
    LoadEn = 1'b0;
    exp_v = {2'b10, 32'h70411802}; got_v = obs(0);
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL collision_old got=%h exp=%h", got_v, exp_v); end
    step();
    exp_v = {2'b10, 32'h00000000}; got_v = obs(0);
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL collision_new got=%h exp=%h", got_v, exp_v); end
    ReqEn = 1'b0;
  endtask

  task automatic test_reset_midflight();
    flush();
    ReqEn = 1'b1; InstrAddr = 32'h0000; step();
    InstrAddr = 32'h0004; step();
    InstrAddr = 32'h0008; step();
    ReqEn = 1'b0;
    got_v = obs(3);
    checks++;
    if (got_v !== 34'h0) begin errors++; $display("FAIL midflight_l4_pre got=%h exp=%h", got_v, 34'h0); end
    #3 nReset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      got_v = obs(k);
      checks++;
      if (got_v !== 34'h0) begin errors++; $display("FAIL midflight_async_l%0d got=%h exp=%h", k + 1, got_v, 34'h0); end
    end
    step();
    nReset = 1'b1;
    for (int e = 0; e < 5; e++) begin
      step();
      got_v = obs(3);
      checks++;
      if (got_v !== 34'h0) begin errors++; $display("FAIL midflight_stale%0d got=%h exp=%h", e, got_v, 34'h0); end
    end
    ReqEn = 1'b1; InstrAddr = 32'h0004;
    step();
    ReqEn = 1'b0;
    exp_v = {2'b10, 32'h34215678}; got_v = obs(0);
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL midflight_array_l1 got=%h exp=%h", got_v, exp_v); end
    repeat (3) step();
    got_v = obs(3);
    checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL midflight_array_l4 got=%h exp=%h", got_v, exp_v); end
  endtask

  initial begin
    nReset    = 1'b0;
    ReqEn     = 1'b0;
    InstrAddr = '0;
    Stall     = 1'b0;
    LoadEn    = 1'b0;
    LoadAddr  = '0;
    LoadData  = '0;
    #1;
    test_reset();
    test_load_single();
    test_deep_pipeline();
    test_illegal();
    test_stall();
    test_collision();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
